// File: rtl/rbsp_bit_writer_pkg.sv
// rbsp_bit_writer_pkg: shared constants, EP-stage state type and zero-run helper
package rbsp_bit_writer_pkg;
  localparam logic [4:0] RBSP_TRAILING_LEN = 5'h1f;
  localparam logic [7:0] EP_BYTE = 8'h03;
  localparam int RBSP_MAX_LEN = 24;
  typedef enum logic {EP_PASS, EP_HELD} ep_state_t;
  function automatic logic [1:0] zero_run_next(logic [1:0] zr, logic [7:0] b);
    return (b == 8'h00) ? ((zr == 2'd2) ? 2'd2 : zr + 2'd1) : 2'd0;
  endfunction
endpackage

// File: rtl/rbsp_bit_writer_if.sv
// rbsp_bit_writer_if: code-write and byte-output handshake bundle
interface rbsp_bit_writer_if #(parameter int MAX_LEN = 24);
  logic               ena;
  logic               sop_in;
  logic               wr_valid_in;
  logic               wr_ready_out;
  logic [MAX_LEN-1:0] bits_in;
  logic [4:0]         len_in;
  logic [7:0]         byte_out;
  logic               byte_valid_out;
  logic               byte_ready_in;
  logic [31:0]        bit_count_out;
  logic               idle_out;
  logic               err_out;
  modport slave (
    input  ena, sop_in, wr_valid_in, bits_in, len_in, byte_ready_in,
    output wr_ready_out, byte_out, byte_valid_out, bit_count_out, idle_out, err_out
  );
  modport master (
    output ena, sop_in, wr_valid_in, bits_in, len_in, byte_ready_in,
    input  wr_ready_out, byte_out, byte_valid_out, bit_count_out, idle_out, err_out
  );
endinterface

// File: rtl/rbsp_bit_writer_ep.sv
// rbsp_bit_writer_ep: emulation-prevention inserter with a registered byte output
module rbsp_bit_writer_ep
  import rbsp_bit_writer_pkg::*;
#(
  parameter int EP_ENABLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       sop,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       empty
);
  ep_state_t  state_q, state_d;
  logic [7:0] hold_q, hold_d, out_q, out_d;
  logic       ov_q, ov_d;
  logic [1:0] zr_q, zr_d;
  logic       load, insert;
  // next output byte: a held candidate first, else the incoming byte or an inserted 0x03
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    out_d    = out_q;
    ov_d     = ov_q;
    zr_d     = zr_q;
    load     = ena & (!ov_q | out_ready);
    in_ready = load & (state_q == EP_PASS);
    insert   = (EP_ENABLE != 0) && (zr_q == 2'd2) && (in_byte <= EP_BYTE);
    if (load) begin
      ov_d = (state_q == EP_HELD) | in_valid;
      if (state_q == EP_HELD) begin
        out_d   = hold_q;
        zr_d    = zero_run_next(zr_q, hold_q);
        state_d = EP_PASS;
      end else if (in_valid && insert) begin
        out_d   = EP_BYTE;
        hold_d  = in_byte;
        zr_d    = 2'd0;
        state_d = EP_HELD;
      end else if (in_valid) begin
        out_d = in_byte;
        zr_d  = zero_run_next(zr_q, in_byte);
      end
    end
    if (ena & sop) zr_d = 2'd0;
  end
  // state, hold and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EP_PASS;
      hold_q  <= 8'h00;
      out_q   <= 8'h00;
      ov_q    <= 1'b0;
      zr_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      zr_q    <= zr_d;
    end
  end
  assign out_byte  = out_q;
  assign out_valid = ov_q;
  assign empty     = (state_q == EP_PASS) & !ov_q;
endmodule

// File: rtl/rbsp_bit_writer.sv
// rbsp_bit_writer: packs variable-length codes MSB-first into bytes with EP insertion
module rbsp_bit_writer
  import rbsp_bit_writer_pkg::*;
#(
  parameter int EP_ENABLE = 1,
  parameter int ACC_W     = 32,
  parameter int MAX_LEN   = RBSP_MAX_LEN
) (
  input logic              clk,
  input logic              rst_n,
  rbsp_bit_writer_if.slave bus
);
  localparam int FW = $clog2(ACC_W + 1);
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [FW-1:0]      fill_q, fill_d, base_fill;
  logic [31:0]        cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               accept, drain, trailing, bad, ep_ready, ep_valid, ep_empty;
  logic [3:0]         pad;
  logic [4:0]         len_eff;
  logic [MAX_LEN-1:0] raw, code;
  // accumulator update: optional drain of the top byte combined with appending the accepted code
  always_comb begin
    accept    = bus.ena & bus.wr_valid_in & bus.wr_ready_out;
    drain     = (fill_q >= FW'(8)) & ep_ready;
    trailing  = bus.len_in == RBSP_TRAILING_LEN;
    bad       = !trailing && (bus.len_in > 5'(MAX_LEN));
    pad       = 4'd8 - {1'b0, fill_q[2:0]};
    len_eff   = (!accept || bad) ? 5'd0 : trailing ? {1'b0, pad} : bus.len_in;
    raw       = trailing ? MAX_LEN'(1) << (pad - 4'd1) : bus.bits_in;
    code      = raw & ((MAX_LEN'(1) << len_eff) - MAX_LEN'(1));
    base_fill = drain ? fill_q - FW'(8) : fill_q;
    acc_d     = (drain ? acc_q << 8 : acc_q) |
                (ACC_W'(code) << (FW'(ACC_W) - base_fill - FW'(len_eff)));
    fill_d    = base_fill + FW'(len_eff);
    cnt_d     = cnt_q + 32'(len_eff);
    err_d     = err_q | (accept & bad);
  end
  // accumulator, fill, bit counter and sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end
  rbsp_bit_writer_ep #(.EP_ENABLE(EP_ENABLE)) u_ep (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (bus.ena),
    .sop       (bus.sop_in),
    .in_byte   (acc_q[ACC_W-1 -: 8]),
    .in_valid  (fill_q >= FW'(8)),
    .in_ready  (ep_ready),
    .out_byte  (bus.byte_out),
    .out_valid (ep_valid),
    .out_ready (bus.byte_ready_in),
    .empty     (ep_empty)
  );
  assign bus.byte_valid_out = ep_valid;
  assign bus.wr_ready_out   = fill_q <= FW'(ACC_W - MAX_LEN);
  assign bus.bit_count_out  = cnt_q;
  assign bus.err_out        = err_q;
  assign bus.idle_out       = (fill_q == '0) & ep_empty & !ep_valid;
endmodule
